// File: rtl/jambu_ise_pkg.sv
// Shared decode constants, op encoding and result-record type for the Jambu ISE issue stage.
package jambu_ise_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [2:0] F3_RORI    = 3'b101;
    localparam logic [2:0] F3_XNOR    = 3'b100;
    localparam logic [6:0] F7_RORI    = 7'b0110000;
    localparam logic [6:0] F7_XNOR    = 7'b0100000;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_RORI = 2'd1,
        OP_XNOR = 2'd2
    } op_e;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        illegal;
    } res_t;

endpackage

// File: rtl/jambu_ise_decode.sv
// Combinational Zbb decoder for rori/xnor; anything else is flagged illegal.
module jambu_ise_decode
    import jambu_ise_pkg::*;
(
    input  logic [31:0] instr_i,
    output op_e         op_o,
    output logic [4:0]  imm_o,
    output logic [4:0]  rd_o,
    output logic        illegal_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign imm_o  = instr_i[24:20];
    assign rd_o   = instr_i[11:7];

    always_comb begin
        op_o = OP_NONE;
        if (opcode == OPC_OP_IMM && funct3 == F3_RORI && funct7 == F7_RORI) begin
            op_o = OP_RORI;
        end else if (opcode == OPC_OP && funct3 == F3_XNOR && funct7 == F7_XNOR) begin
            op_o = OP_XNOR;
        end
    end

    assign illegal_o = (op_o == OP_NONE);

endmodule

// File: rtl/jambu_ise_issue.sv
// Two-stage issue/retire pipe for the Jambu ISE datapath with flush support.
// Define JAMBU_ISE_SKID_EN to add a 1-entry skid behind stage B and register in_ready.
module jambu_ise_issue
    import jambu_ise_pkg::*;
(
    input  logic        g_clk,
    input  logic        g_rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    output logic [31:0] dp_rs1,
    output logic [31:0] dp_rs2,
    output logic [4:0]  dp_imm,
    output logic        dp_op_rori,
    output logic        dp_op_xnor,
    input  logic [31:0] dp_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd_addr,
    output logic        out_illegal,
    output logic [15:0] retired
);

    op_e         dec_op;
    logic [4:0]  dec_imm;
    logic [4:0]  dec_rd;
    logic        dec_ill;

    jambu_ise_decode u_decode (
        .instr_i   (in_instr),
        .op_o      (dec_op),
        .imm_o     (dec_imm),
        .rd_o      (dec_rd),
        .illegal_o (dec_ill)
    );

    logic        va_q, va_d;
    op_e         op_a_q;
    logic [31:0] rs1_a_q, rs2_a_q;
    logic [4:0]  imm_a_q, rd_a_q;
    logic        ill_a_q;
    logic        vb_q, vb_d;
    res_t        b_q, b_d;
    res_t        res_a;
    logic [15:0] retired_q, retired_d;
    logic        out_fire, in_fire, a_leave, a_to_b;

    assign out_fire = vb_q & out_ready;

    always_comb begin
        res_a.result  = ill_a_q ? 32'd0 : dp_rd;
        res_a.rd      = rd_a_q;
        res_a.illegal = ill_a_q;
    end

`ifdef JAMBU_ISE_SKID_EN
    logic vs_q, vs_d;
    res_t s_q, s_d;
    logic a_to_s;

    // A may leave into B or the skid; the skid only fills while B is occupied.
    assign a_leave  = va_q & (!vb_q | !vs_q | out_fire) & !flush;
    assign a_to_b   = a_leave & (!vb_q | (out_fire & !vs_q));
    assign a_to_s   = a_leave & !a_to_b;
    assign in_ready = !flush & (!va_q | !vb_q | !vs_q);

    always_comb begin
        vs_d = vs_q;
        s_d  = s_q;
        if (flush) begin
            vs_d = 1'b0;
        end else if (a_to_s) begin
            vs_d = 1'b1;
            s_d  = res_a;
        end else if (out_fire) begin
            vs_d = 1'b0;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            vs_q <= 1'b0;
            s_q  <= '0;
        end else begin
            vs_q <= vs_d;
            s_q  <= s_d;
        end
    end
`else
    assign a_leave  = va_q & (!vb_q | out_fire) & !flush;
    assign a_to_b   = a_leave;
    assign in_ready = !flush & (!va_q | a_leave);
`endif

    assign in_fire = in_valid & in_ready;

    always_comb begin
        va_d = va_q;
        if (flush) begin
            va_d = 1'b0;
        end else if (in_fire) begin
            va_d = 1'b1;
        end else if (a_leave) begin
            va_d = 1'b0;
        end
    end

    always_comb begin
        vb_d = vb_q;
        b_d  = b_q;
        if (flush) begin
            vb_d = 1'b0;
`ifdef JAMBU_ISE_SKID_EN
        end else if (out_fire && vs_q) begin
            vb_d = 1'b1;
            b_d  = s_q;
`endif
        end else if (a_to_b) begin
            vb_d = 1'b1;
            b_d  = res_a;
        end else if (out_fire) begin
            vb_d = 1'b0;
        end
    end

    // An out_fire coinciding with flush is not a retirement.
    always_comb begin
        retired_d = retired_q;
        if (!flush && out_fire && !b_q.illegal && retired_q != 16'hFFFF) begin
            retired_d = retired_q + 16'd1;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            va_q      <= 1'b0;
            op_a_q    <= OP_NONE;
            rs1_a_q   <= '0;
            rs2_a_q   <= '0;
            imm_a_q   <= '0;
            rd_a_q    <= '0;
            ill_a_q   <= 1'b0;
            vb_q      <= 1'b0;
            b_q       <= '0;
            retired_q <= '0;
        end else begin
            va_q      <= va_d;
            vb_q      <= vb_d;
            b_q       <= b_d;
            retired_q <= retired_d;
            if (in_fire) begin
                op_a_q  <= dec_op;
                rs1_a_q <= in_rs1;
                rs2_a_q <= in_rs2;
                imm_a_q <= dec_imm;
                rd_a_q  <= dec_rd;
                ill_a_q <= dec_ill;
            end
        end
    end

    assign dp_op_rori  = va_q & (op_a_q == OP_RORI);
    assign dp_op_xnor  = va_q & (op_a_q == OP_XNOR);
    assign dp_rs1      = va_q ? rs1_a_q : 32'd0;
    assign dp_rs2      = va_q ? rs2_a_q : 32'd0;
    assign dp_imm      = va_q ? imm_a_q : 5'd0;
    assign out_valid   = vb_q;
    assign out_result  = b_q.result;
    assign out_rd_addr = b_q.rd;
    assign out_illegal = b_q.illegal;
    assign retired     = retired_q;

endmodule
